// File: rtl/past_cause_checker.sv
// past_cause_checker
//
// Synthesizable past-looking temporal checker for the in-design monitor library.
// Rule: whenever b is sampled high, a must have been sampled high exactly DELAY
// enabled cycles earlier (b |-> $past(a, DELAY)). The block looks back from the
// effect to its cause rather than forward from the cause.
//
// Parameters:
//   DELAY  look-back distance in enabled cycles, legal range 1..15
//   CNT_W  width of the pass, fail, skip and cycle counters
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   en              check enable; low freezes sampling, checking and cyc_cnt
//   clr             synchronous clear of history, counters and error state
//   a               cause signal (synchronous to clk)
//   b               effect signal (synchronous to clk)
//   pass_pulse      one-cycle pulse, a check passed
//   fail_pulse      one-cycle pulse, a check failed
//   pass_cnt        saturating pass count
//   fail_cnt        saturating fail count
//   skip_cnt        saturating count of b=1 samples ignored during warm-up
//   err_sticky      set on the first failure, held until rst or clr
//   first_fail_cyc  cyc_cnt value captured at the first failure
//   cyc_cnt         enabled-cycle counter, wraps
//   armed           high once DELAY history samples are valid
module past_cause_checker #(
    parameter int unsigned DELAY = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic             err_sticky,
    output logic [CNT_W-1:0] first_fail_cyc,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             armed
);

    if (DELAY < 1 || DELAY > 15) begin : g_bad_delay
        $error("past_cause_checker: DELAY must be in 1..15");
    end

    typedef enum logic [0:0] {StFill, StCheck} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [DELAY-1:0]   hist_q, hist_d;
    logic [3:0]         fill_cnt_q, fill_cnt_d;
    logic [3:0]         fill_next;
    logic               pass_pulse_q, pass_pulse_d;
    logic               fail_pulse_q, fail_pulse_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   first_fail_q, first_fail_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic               armed_q, armed_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    assign fill_next = fill_cnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        fill_cnt_d   = fill_cnt_q;
        pass_pulse_d = 1'b0;
        fail_pulse_d = 1'b0;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;
        cyc_d        = cyc_q;

        if (clr) begin
            // Clear wins over en; a b sample on this edge is dropped entirely.
            state_d      = StFill;
            hist_d       = '0;
            fill_cnt_d   = '0;
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
            skip_cnt_d   = '0;
            err_d        = 1'b0;
            first_fail_d = '0;
            cyc_d        = '0;
        end else if (en) begin
            hist_d[0] = a;
            for (int i = 1; i < int'(DELAY); i++) begin
                hist_d[i] = hist_q[i-1];
            end
            cyc_d = cyc_q + CNT_W'(1);

            unique case (state_q)
                StFill: begin
                    fill_cnt_d = fill_next;
                    if (b) begin
                        skip_cnt_d = sat_inc(skip_cnt_q);
                    end
                    if (fill_next == 4'(DELAY)) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    // hist_q is the pre-shift view: bit DELAY-1 is a from DELAY
                    // enabled edges before this one.
                    if (b) begin
                        if (hist_q[DELAY-1]) begin
                            pass_pulse_d = 1'b1;
                            pass_cnt_d   = sat_inc(pass_cnt_q);
                        end else begin
                            fail_pulse_d = 1'b1;
                            fail_cnt_d   = sat_inc(fail_cnt_q);
                            if (!err_q) begin
                                err_d        = 1'b1;
                                first_fail_d = cyc_q;
                            end
                        end
                    end
                end
                default: begin
                    state_d = StFill;
                end
            endcase
        end

        armed_d = (state_d == StCheck);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFill;
            hist_q       <= '0;
            fill_cnt_q   <= '0;
            pass_pulse_q <= 1'b0;
            fail_pulse_q <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            skip_cnt_q   <= '0;
            err_q        <= 1'b0;
            first_fail_q <= '0;
            cyc_q        <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            fill_cnt_q   <= fill_cnt_d;
            pass_pulse_q <= pass_pulse_d;
            fail_pulse_q <= fail_pulse_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            cyc_q        <= cyc_d;
            armed_q      <= armed_d;
        end
    end

    assign pass_pulse     = pass_pulse_q;
    assign fail_pulse     = fail_pulse_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign skip_cnt       = skip_cnt_q;
    assign err_sticky     = err_q;
    assign first_fail_cyc = first_fail_q;
    assign cyc_cnt        = cyc_q;
    assign armed          = armed_q;

endmodule
